vga_rect_fill: RTL and testbench

VGA_RECT_FILL -- requirements
Module: vga_rect_fill

---
 rtl/vga_pkg.sv | 17 +
 rtl/vga_xy_counter.sv | 46 ++++
 rtl/vga_rect_fill.sv | 142 ++++++++++++++
 tb/tb_vga_rect_fill.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared encodings for the VGA rectangle drawing block: command modes and FSM states.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_FILL    = 2'd0,
    MODE_CLEAR   = 2'd1,
    MODE_OUTLINE = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/vga_xy_counter.sv
// Raster x/y counter: x runs from i_x_lo to i_x_hi, then wraps and y steps; o_last flags the final pixel.
module vga_xy_counter #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic           i_clk,
  input  logic           i_resetn,
  input  logic           i_load,
  input  logic           i_en,
  input  logic [X_W-1:0] i_x_ld,
  input  logic [Y_W-1:0] i_y_ld,
  input  logic [X_W-1:0] i_x_lo,
  input  logic [X_W-1:0] i_x_hi,
  input  logic [Y_W-1:0] i_y_hi,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_last
);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           w_row_end;

  assign w_row_end = (r_x == i_x_hi);
  assign o_last    = w_row_end && (r_y == i_y_hi);
  assign o_x       = r_x;
  assign o_y       = r_y;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_load) begin
      r_x <= i_x_ld;
      r_y <= i_y_ld;
    end else if (i_en) begin
      if (w_row_end) begin
        r_x <= i_x_lo;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle fill / clear / outline engine emitting one pixel write per cycle in raster order.
module vga_rect_fill
  import vga_pkg::*;
#(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 3,
  parameter int X_MAX   = 159,
  parameter int Y_MAX   = 119
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [X_W:0]       w,
  input  logic [Y_W:0]       h,
  input  logic [COLOR_W-1:0] color,
  output logic [X_W-1:0]     VGA_X,
  output logic [Y_W-1:0]     VGA_Y,
  output logic [COLOR_W-1:0] VGA_COLOR,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  // Two spare bits so x0+w-1 never wraps before clipping.
  localparam int XS = X_W + 2;
  localparam int YS = Y_W + 2;
  localparam logic [XS-1:0] XMAX_S = XS'(X_MAX);
  localparam logic [YS-1:0] YMAX_S = YS'(Y_MAX);

  state_e r_state, w_state_nxt;

  logic [COLOR_W-1:0] r_color;
  logic               r_outline;
  logic [X_W-1:0]     r_x0, r_xe;
  logic [Y_W-1:0]     r_y0, r_ye;

  logic               w_clear;
  logic [X_W-1:0]     w_x0;
  logic [Y_W-1:0]     w_y0;
  logic [X_W:0]       w_w;
  logic [Y_W:0]       w_h;
  logic [XS-1:0]      w_xe_full;
  logic [YS-1:0]      w_ye_full;
  logic [X_W-1:0]     w_xe;
  logic [Y_W-1:0]     w_ye;
  logic               w_empty;
  logic               w_latch;
  logic               w_cnt_en;
  logic [X_W-1:0]     w_cx;
  logic [Y_W-1:0]     w_cy;
  logic               w_last;
  logic               w_edge;

  assign w_clear = (mode == MODE_CLEAR);
  assign w_x0    = w_clear ? '0 : x0;
  assign w_y0    = w_clear ? '0 : y0;
  assign w_w     = w_clear ? (X_W+1)'(X_MAX + 1) : w;
  assign w_h     = w_clear ? (Y_W+1)'(Y_MAX + 1) : h;

  assign w_xe_full = XS'(w_x0) + XS'(w_w) - XS'(1);
  assign w_ye_full = YS'(w_y0) + YS'(w_h) - YS'(1);
  assign w_xe      = (w_xe_full > XMAX_S) ? X_W'(X_MAX) : w_xe_full[X_W-1:0];
  assign w_ye      = (w_ye_full > YMAX_S) ? Y_W'(Y_MAX) : w_ye_full[Y_W-1:0];

  assign w_empty = (w_w == '0) || (w_h == '0) ||
                   (XS'(w_x0) > XMAX_S) || (YS'(w_y0) > YMAX_S);

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_latch     = 1'b1;
          w_state_nxt = w_empty ? ST_DONE : ST_DRAW;
        end
      end
      ST_DRAW: begin
        w_cnt_en = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_color   <= '0;
      r_outline <= 1'b0;
      r_x0      <= '0;
      r_y0      <= '0;
      r_xe      <= '0;
      r_ye      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_color   <= color;
        r_outline <= (mode == MODE_OUTLINE);
        r_x0      <= w_x0;
        r_y0      <= w_y0;
        r_xe      <= w_xe;
        r_ye      <= w_ye;
      end
    end
  end

  vga_xy_counter #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_xy (
    .i_clk    (CLOCK_50),
    .i_resetn (resetn),
    .i_load   (w_latch),
    .i_en     (w_cnt_en),
    .i_x_ld   (w_x0),
    .i_y_ld   (w_y0),
    .i_x_lo   (r_x0),
    .i_x_hi   (r_xe),
    .i_y_hi   (r_ye),
    .o_x      (w_cx),
    .o_y      (w_cy),
    .o_last   (w_last)
  );

  // Outline mode still walks every pixel of the box, it just masks the interior strobes.
  assign w_edge = (w_cx == r_x0) || (w_cx == r_xe) || (w_cy == r_y0) || (w_cy == r_ye);

  assign VGA_X     = w_cx;
  assign VGA_Y     = w_cy;
  assign VGA_COLOR = r_color;
  assign plot      = (r_state == ST_DRAW) && (!r_outline || w_edge);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: table of commands with hand-computed results plus reset/DONE corner sequences.
module tb_vga_rect_fill;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       start    = 1'b0;
  logic [1:0] mode     = '0;
  logic [7:0] x0       = '0;
  logic [6:0] y0       = '0;
  logic [8:0] w        = '0;
  logic [7:0] h        = '0;
  logic [2:0] color    = '0;
  logic [7:0] VGA_X;
  logic [6:0] VGA_Y;
  logic [2:0] VGA_COLOR;
  logic       plot, busy, done;

  vga_rect_fill dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .start     (start),
    .mode      (mode),
    .x0        (x0),
    .y0        (y0),
    .w         (w),
    .h         (h),
    .color     (color),
    .VGA_X     (VGA_X),
    .VGA_Y     (VGA_Y),
    .VGA_COLOR (VGA_COLOR),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int mode, x0, y0, w, h, color;
    int plots, dcyc;            // expected plot pulses and DRAW cycles
    int fx, fy, lx, ly;         // first / last plotted pixel
    int xlo, xhi, ylo, yhi;     // clipped box every plot must fall inside
    int hx, hy;                 // pixel that must not be plotted (-1: none)
  } vec_t;

  function automatic vec_t mk(int md, int ax, int ay, int aw, int ah, int c, int np, int dc,
                              int fx, int fy, int lx, int ly, int hx, int hy);
    vec_t v;
    v.mode = md; v.x0 = ax; v.y0 = ay; v.w = aw; v.h = ah; v.color = c;
    v.plots = np; v.dcyc = dc;
    v.fx = fx; v.fy = fy; v.lx = lx; v.ly = ly;
    v.xlo = fx; v.ylo = fy; v.xhi = lx; v.yhi = ly;
    v.hx = hx; v.hy = hy;
    return v;
  endfunction

  task automatic run_cmd(input int idx, input vec_t v);
    int np, nd, nb, dt, bad_col, bad_box, bad_ord, hole, prev, p;
    int fx, fy, lx, ly;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge CLOCK_50);
    mode  = 2'(v.mode);
    x0    = 8'(v.x0);
    y0    = 7'(v.y0);
    w     = 9'(v.w);
    h     = 8'(v.h);
    color = 3'(v.color);
    start = 1'b1;
    @(posedge CLOCK_50);
    #1 start = 1'b0;
    np = 0; nd = 0; nb = 0; dt = -1; bad_col = 0; bad_box = 0; bad_ord = 0; hole = 0;
    prev = -1; fx = -1; fy = -1; lx = -1; ly = -1;
    for (int t = 1; t <= 20000 && dt < 0; t++) begin
      @(negedge CLOCK_50);
      if (busy) nb++;
      if (done) begin nd++; dt = t; end
      if (plot) begin
        np++;
        p = int'(VGA_Y) * 160 + int'(VGA_X);
        if (p <= prev) bad_ord++;
        prev = p;
        if (fx < 0) begin fx = int'(VGA_X); fy = int'(VGA_Y); end
        lx = int'(VGA_X); ly = int'(VGA_Y);
        if (int'(VGA_COLOR) != v.color) bad_col++;
        if (int'(VGA_X) < v.xlo || int'(VGA_X) > v.xhi ||
            int'(VGA_Y) < v.ylo || int'(VGA_Y) > v.yhi) bad_box++;
        if (int'(VGA_X) == v.hx && int'(VGA_Y) == v.hy) hole++;
      end
    end
    chk({tag, ".plots"},      np, v.plots);
    chk({tag, ".done_cycle"}, dt, v.dcyc + 1);
    chk({tag, ".busy_cycles"}, nb, v.dcyc + 1);
    chk({tag, ".done_pulses"}, nd, 1);
    chk({tag, ".colour_errs"}, bad_col, 0);
    chk({tag, ".box_errs"},    bad_box, 0);
    chk({tag, ".order_errs"},  bad_ord, 0);
    if (v.plots > 0) begin
      chk({tag, ".first_x"}, fx, v.fx);
      chk({tag, ".first_y"}, fy, v.fy);
      chk({tag, ".last_x"},  lx, v.lx);
      chk({tag, ".last_y"},  ly, v.ly);
    end
    if (v.hx >= 0) chk({tag, ".interior_hole"}, hole, 0);
    @(negedge CLOCK_50);
    chk({tag, ".idle_busy"}, int'(busy), 0);
    chk({tag, ".idle_done"}, int'(done), 0);
  endtask

  vec_t vecs[12];
  int   np, nd;

  initial begin
    vecs[0]  = mk(0, 10, 20, 3, 2, 5,      6,     6,  10, 20,  12,  21, -1, -1);
    vecs[1]  = mk(0, 158, 118, 4, 4, 3,    4,     4, 158, 118, 159, 119, -1, -1);
    vecs[2]  = mk(1, 77, 33, 1, 1, 0,  19200, 19200,   0,  0, 159, 119, -1, -1);
    vecs[3]  = mk(2, 0, 0, 4, 3, 6,       10,    12,   0,  0,   3,   2,  1,  1);
    vecs[4]  = mk(0, 10, 10, 0, 5, 1,      0,     0,   0,  0,   0,   0, -1, -1);
    vecs[5]  = mk(0, 200, 10, 3, 3, 1,     0,     0,   0,  0,   0,   0, -1, -1);
    vecs[6]  = mk(3, 5, 5, 2, 2, 7,        4,     4,   5,  5,   6,   6, -1, -1);
    vecs[7]  = mk(2, 5, 5, 3, 3, 2,        8,     9,   5,  5,   7,   7,  6,  6);
    vecs[8]  = mk(0, 10, 10, 5, 0, 1,      0,     0,   0,  0,   0,   0, -1, -1);
    vecs[9]  = mk(0, 10, 120, 5, 5, 1,     0,     0,   0,  0,   0,   0, -1, -1);
    vecs[10] = mk(2, 7, 3, 1, 3, 4,        3,     3,   7,  3,   7,   5, -1, -1);
    vecs[11] = mk(0, 150, 0, 511, 1, 2,   10,    10, 150,  0, 159,   0, -1, -1);

    // Reset state
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("rst.plot",  int'(plot), 0);
    chk("rst.busy",  int'(busy), 0);
    chk("rst.done",  int'(done), 0);
    chk("rst.vga_x", int'(VGA_X), 0);
    chk("rst.vga_y", int'(VGA_Y), 0);
    chk("rst.color", int'(VGA_COLOR), 0);
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) run_cmd(i, vecs[i]);

    // Second outline interior pixel of the 4x3 box
    begin
      int hole2 = 0;
      @(negedge CLOCK_50);
      mode = 2'd2; x0 = 8'd0; y0 = 7'd0; w = 9'd4; h = 8'd3; color = 3'd6; start = 1'b1;
      @(posedge CLOCK_50);
      #1 start = 1'b0;
      for (int t = 0; t < 13; t++) begin
        @(negedge CLOCK_50);
        if (plot && VGA_X == 8'd2 && VGA_Y == 7'd1) hole2++;
      end
      chk("outline.hole_2_1", hole2, 0);
      @(negedge CLOCK_50);
    end

    // Start held in the DONE cycle is dropped
    @(negedge CLOCK_50);
    mode = 2'd0; x0 = 8'd0; y0 = 7'd0; w = 9'd0; h = 8'd4; start = 1'b1;
    @(negedge CLOCK_50);
    chk("donedrop.t1_done", int'(done), 1);
    chk("donedrop.t1_busy", int'(busy), 1);
    @(negedge CLOCK_50);
    chk("donedrop.t2_busy", int'(busy), 0);
    chk("donedrop.t2_done", int'(done), 0);
    start = 1'b0;
    @(negedge CLOCK_50);
    chk("donedrop.t3_busy", int'(busy), 0);

    // Reset at pixel 3 of a 5x5 fill with start held high throughout
    @(negedge CLOCK_50);
    mode = 2'd0; x0 = 8'd30; y0 = 7'd40; w = 9'd5; h = 8'd5; color = 3'd4; start = 1'b1;
    np = 0; nd = 0;
    for (int t = 0; t < 20 && np < 3; t++) begin
      @(negedge CLOCK_50);
      if (plot) np++;
      if (done) nd++;
    end
    chk("rstmid.plots_before", np, 3);
    chk("rstmid.pixel3_x", int'(VGA_X), 32);
    chk("rstmid.pixel3_y", int'(VGA_Y), 40);
    resetn = 1'b0;
    @(negedge CLOCK_50);
    chk("rstmid.plot",  int'(plot), 0);
    chk("rstmid.busy",  int'(busy), 0);
    chk("rstmid.done",  int'(done), 0);
    chk("rstmid.vga_x", int'(VGA_X), 0);
    chk("rstmid.vga_y", int'(VGA_Y), 0);
    chk("rstmid.color", int'(VGA_COLOR), 0);
    @(negedge CLOCK_50);
    chk("rstmid.prio_busy", int'(busy), 0);
    start  = 1'b0;
    resetn = 1'b1;
    np = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge CLOCK_50);
      if (plot) np++;
      if (done) nd++;
    end
    chk("rstmid.done_pulses", nd, 0);
    chk("rstmid.plots_after", np, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
